// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - tinyriscv memory-access stage between execute and writeback

package tinyriscv_pkg;
   parameter int RegBus     = 32;
   parameter int RegAddrBus = 5;
endpackage

module mem_stage
   import tinyriscv_pkg::*;
#(
   parameter int AddrWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ex_valid_i,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [1:0]            mem_size_i,
   input  logic                  mem_unsigned_i,
   input  logic [AddrWidth-1:0]  mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   input  logic [RegAddrBus-1:0] reg_waddr_i,
   input  logic [RegBus-1:0]     reg_wdata_i,
   input  logic                  reg_wen_i,
   output logic                  stall_o,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [AddrWidth-1:0]  data_addr_o,
   output logic [31:0]           data_wdata_o,
   input  logic                  data_rvalid_i,
   input  logic [31:0]           data_rdata_i,
   input  logic                  data_err_i,
   output logic                  misaligned_o,
   output logic                  bus_err_o,
   output logic [RegAddrBus-1:0] reg_waddr_o,
   output logic [RegBus-1:0]     reg_wdata_o,
   output logic                  reg_wen_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e state_q, state_d;

   // Operation captured at accept time; execute is free to change its outputs afterwards.
   logic                  op_we_q;
   logic [1:0]            op_size_q;
   logic                  op_uns_q;
   logic [AddrWidth-1:0]  op_addr_q;
   logic [31:0]           op_wdata_q;
   logic [RegAddrBus-1:0] op_waddr_q;
   logic                  op_wen_q;

   logic        misaligned_in;
   logic        accept;
   logic [3:0]  be_lat;
   logic [31:0] wdata_lat;
   logic [31:0] rdata_shifted;
   logic [31:0] load_value;

   // Alignment check on the incoming request; size 11 is treated as misaligned.
   always_comb begin
      misaligned_in = 1'b0;
      case (mem_size_i)
         2'b00:   misaligned_in = 1'b0;
         2'b01:   misaligned_in = mem_addr_i[0];
         2'b10:   misaligned_in = |mem_addr_i[1:0];
         default: misaligned_in = 1'b1;
      endcase
   end

   assign accept = (state_q == IDLE) && ex_valid_i && mem_req_i && !misaligned_in;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: request until granted, then wait for the response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = REQ;
         REQ:     if (data_gnt_i) state_d = WAIT;
         WAIT:    if (data_rvalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are driven only in REQ, so they fall to zero the moment reset hits.
   always_comb begin
      stall_o      = (state_q != IDLE);
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_be_o    = 4'b0000;
      data_addr_o  = '0;
      data_wdata_o = 32'h0;
      if (state_q == REQ) begin
         data_req_o   = 1'b1;
         data_we_o    = op_we_q;
         data_be_o    = be_lat;
         data_addr_o  = {op_addr_q[AddrWidth-1:2], 2'b00};
         data_wdata_o = wdata_lat;
      end
   end

   // Capture the memory operation when it is accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_we_q    <= 1'b0;
         op_size_q  <= 2'b00;
         op_uns_q   <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= 32'h0;
         op_waddr_q <= '0;
         op_wen_q   <= 1'b0;
      end else if (accept) begin
         op_we_q    <= mem_we_i;
         op_size_q  <= mem_size_i;
         op_uns_q   <= mem_unsigned_i;
         op_addr_q  <= mem_addr_i;
         op_wdata_q <= mem_wdata_i;
         op_waddr_q <= reg_waddr_i;
         op_wen_q   <= reg_wen_i;
      end
   end

   // Byte enables and lane-replicated store data from the latched operation.
   always_comb begin
      be_lat    = 4'b1111;
      wdata_lat = op_wdata_q;
      case (op_size_q)
         2'b00: begin
            be_lat    = 4'b0001 << op_addr_q[1:0];
            wdata_lat = {4{op_wdata_q[7:0]}};
         end
         2'b01: begin
            be_lat    = 4'b0011 << op_addr_q[1:0];
            wdata_lat = {2{op_wdata_q[15:0]}};
         end
         default: begin
            be_lat    = 4'b1111;
            wdata_lat = op_wdata_q;
         end
      endcase
   end

   assign rdata_shifted = data_rdata_i >> {op_addr_q[1:0], 3'b000};

   // Load extraction: pick the addressed lanes and sign- or zero-extend.
   always_comb begin
      load_value = rdata_shifted;
      case (op_size_q)
         2'b00:   load_value = op_uns_q ? {24'h0, rdata_shifted[7:0]}
                                        : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         2'b01:   load_value = op_uns_q ? {16'h0, rdata_shifted[15:0]}
                                        : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         default: load_value = rdata_shifted;
      endcase
   end

   // Writeback registers; reg_wen_o and the error flags are single-cycle pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         reg_waddr_o  <= '0;
         reg_wdata_o  <= '0;
         reg_wen_o    <= 1'b0;
         misaligned_o <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         reg_wen_o    <= 1'b0;
         misaligned_o <= 1'b0;
         bus_err_o    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ex_valid_i && !mem_req_i) begin
                  reg_waddr_o <= reg_waddr_i;
                  reg_wdata_o <= reg_wdata_i;
                  reg_wen_o   <= reg_wen_i && (reg_waddr_i != '0);
               end else if (ex_valid_i && misaligned_in) begin
                  misaligned_o <= 1'b1;
               end
            end
            WAIT: begin
               if (data_rvalid_i) begin
                  if (data_err_i) begin
                     bus_err_o <= 1'b1;
                  end else if (!op_we_q) begin
                     reg_waddr_o <= op_waddr_q;
                     reg_wdata_o <= load_value;
                     reg_wen_o   <= op_wen_q && (op_waddr_q != '0);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage

module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [4:0]  reg_waddr_in;
   logic [31:0] reg_wdata_in;
   logic        reg_wen_in;
   logic        stall;
   logic        data_req;
   logic        data_gnt;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_err;
   logic        misaligned;
   logic        bus_err;
   logic [4:0]  reg_waddr_out;
   logic [31:0] reg_wdata_out;
   logic        reg_wen_out;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage #(.AddrWidth(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .ex_valid_i     (ex_valid),
      .mem_req_i      (mem_req),
      .mem_we_i       (mem_we),
      .mem_size_i     (mem_size),
      .mem_unsigned_i (mem_unsigned),
      .mem_addr_i     (mem_addr),
      .mem_wdata_i    (mem_wdata),
      .reg_waddr_i    (reg_waddr_in),
      .reg_wdata_i    (reg_wdata_in),
      .reg_wen_i      (reg_wen_in),
      .stall_o        (stall),
      .data_req_o     (data_req),
      .data_gnt_i     (data_gnt),
      .data_we_o      (data_we),
      .data_be_o      (data_be),
      .data_addr_o    (data_addr),
      .data_wdata_o   (data_wdata),
      .data_rvalid_i  (data_rvalid),
      .data_rdata_i   (data_rdata),
      .data_err_i     (data_err),
      .misaligned_o   (misaligned),
      .bus_err_o      (bus_err),
      .reg_waddr_o    (reg_waddr_out),
      .reg_wdata_o    (reg_wdata_out),
      .reg_wen_o      (reg_wen_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mem;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        wen;
      int          gdly;
      int          rdly;
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic        wb_wen;
      logic [31:0] wb_data;
      logic        chk_data;
      logic        berr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mkv(
      input logic mem, input logic we, input logic [1:0] size, input logic uns,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
      input logic [31:0] alu, input logic wen, input int gdly, input int rdly,
      input logic [31:0] rdata, input logic err,
      input logic mis, input logic [3:0] be, input logic [31:0] baddr,
      input logic [31:0] bwdata, input logic wb_wen, input logic [31:0] wb_data,
      input logic chk_data, input logic berr);
      vec_t v;
      v.mem = mem; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.rd = rd; v.alu = alu; v.wen = wen; v.gdly = gdly;
      v.rdly = rdly; v.rdata = rdata; v.err = err; v.mis = mis; v.be = be;
      v.baddr = baddr; v.bwdata = bwdata; v.wb_wen = wb_wen; v.wb_data = wb_data;
      v.chk_data = chk_data; v.berr = berr;
      return v;
   endfunction

   // Reference model: expected results from byte counts, offsets and plain arithmetic.
   function automatic vec_t model(input vec_t vi);
      vec_t v;
      int unsigned off, nbytes;
      logic [31:0] sh, val, span;
      v = vi;
      v.mis = 0; v.be = 0; v.baddr = 0; v.bwdata = 0;
      v.wb_wen = 0; v.wb_data = 0; v.chk_data = 0; v.berr = 0;
      if (!v.mem) begin
         v.wb_wen = v.wen && (v.rd != 0);
         v.wb_data = v.alu;
         v.chk_data = 1;
         return v;
      end
      off = v.addr % 4;
      nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
      if (v.size == 2'd3 || (off % nbytes) != 0) begin
         v.mis = 1;
         return v;
      end
      v.be = 4'(((1 << nbytes) - 1) << off);
      v.baddr = v.addr - off;
      if (nbytes == 1)      v.bwdata = (v.wdata % 256) * 32'h01010101;
      else if (nbytes == 2) v.bwdata = (v.wdata % 65536) * 32'h00010001;
      else                  v.bwdata = v.wdata;
      if (v.err) begin
         v.berr = 1;
         return v;
      end
      if (v.we) return v;
      sh = v.rdata >> (8 * off);
      if (nbytes == 4) begin
         val = sh;
      end else begin
         span = 32'd1 << (8 * nbytes);
         val = sh % span;
         if (!v.uns && val >= span / 2) val = val - span;
      end
      v.wb_wen = v.wen && (v.rd != 0);
      v.wb_data = val;
      v.chk_data = 1;
      return v;
   endfunction

   task automatic drive_idle();
      ex_valid = 0; mem_req = 0; mem_we = 0; mem_size = 0; mem_unsigned = 0;
      mem_addr = 0; mem_wdata = 0; reg_waddr_in = 0; reg_wdata_in = 0; reg_wen_in = 0;
   endtask

   // Random instruction presented while stalled; the stage must ignore it.
   task automatic drive_garbage();
      ex_valid = 1; mem_req = 1'($urandom); mem_we = 1'($urandom);
      mem_size = 2'($urandom); mem_unsigned = 1'($urandom); mem_addr = $urandom;
      mem_wdata = $urandom; reg_waddr_in = 5'($urandom); reg_wdata_in = $urandom;
      reg_wen_in = 1'($urandom);
   endtask

   task automatic check_bus(input vec_t v, input string tag);
      check({tag, "_req"}, data_req, 1);
      check({tag, "_we"}, data_we, v.we);
      check({tag, "_be"}, data_be, v.be);
      check({tag, "_addr"}, data_addr, v.baddr);
      check({tag, "_wdata"}, data_wdata, v.bwdata);
      check({tag, "_stall"}, stall, 1);
      check({tag, "_wen"}, reg_wen_out, 0);
   endtask

   // Called at posedge+1 with the stage idle; returns at posedge+1 with the stage idle.
   task automatic apply(input vec_t v);
      ex_valid = 1; mem_req = v.mem; mem_we = v.we; mem_size = v.size;
      mem_unsigned = v.uns; mem_addr = v.addr; mem_wdata = v.wdata;
      reg_waddr_in = v.rd; reg_wdata_in = v.alu; reg_wen_in = v.wen;
      @(posedge clk); #1;
      if (!v.mem) begin
         check("alu_stall", stall, 0);
         check("alu_wen", reg_wen_out, v.wb_wen);
         check("alu_waddr", reg_waddr_out, v.rd);
         check("alu_wdata", reg_wdata_out, v.wb_data);
      end else if (v.mis) begin
         check("mis_pulse", misaligned, 1);
         check("mis_wen", reg_wen_out, 0);
         check("mis_req", data_req, 0);
         check("mis_stall", stall, 0);
      end else begin
         check_bus(v, "req");
         for (int i = 0; i < v.gdly; i++) begin
            drive_garbage();
            data_gnt = 0;
            data_rvalid = 1'($urandom);
            data_err = 1'($urandom);
            data_rdata = $urandom;
            @(posedge clk); #1;
            check_bus(v, "hold");
         end
         drive_garbage();
         data_gnt = 1; data_rvalid = 0; data_err = 0;
         @(posedge clk); #1;
         check("gnt_req_drop", data_req, 0);
         check("gnt_stall", stall, 1);
         data_gnt = 0;
         for (int i = 0; i < v.rdly; i++) begin
            drive_garbage();
            @(posedge clk); #1;
            check("wait_stall", stall, 1);
            check("wait_wen", reg_wen_out, 0);
            check("wait_req", data_req, 0);
         end
         drive_garbage();
         data_rvalid = 1; data_rdata = v.rdata; data_err = v.err;
         @(posedge clk); #1;
         data_rvalid = 0; data_err = 0;
         check("done_stall", stall, 0);
         check("done_wen", reg_wen_out, v.wb_wen);
         check("done_buserr", bus_err, v.berr);
         if (v.chk_data) begin
            check("done_wdata", reg_wdata_out, v.wb_data);
            check("done_waddr", reg_waddr_out, v.rd);
         end
      end
      drive_idle();
      data_gnt = 0;
      data_rvalid = 1'($urandom);
      data_err = 1'($urandom);
      @(posedge clk); #1;
      data_rvalid = 0; data_err = 0;
      check("bubble_wen", reg_wen_out, 0);
      check("bubble_mis", misaligned, 0);
      check("bubble_buserr", bus_err, 0);
      check("bubble_stall", stall, 0);
   endtask

   vec_t table_v[15];

   initial begin
      vec_t rv;
      table_v[0]  = mkv(0,0,2'd0,0,32'h0,32'h0,5'd5,32'h1234,1,0,0,32'h0,0,
                        0,4'b0000,32'h0,32'h0,1,32'h1234,1,0);
      table_v[1]  = mkv(0,0,2'd0,0,32'h0,32'h0,5'd0,32'h55,1,0,0,32'h0,0,
                        0,4'b0000,32'h0,32'h0,0,32'h55,1,0);
      table_v[2]  = mkv(1,0,2'd0,0,32'h1003,32'h0,5'd7,32'h0,1,0,0,32'h80AABBCC,0,
                        0,4'b1000,32'h1000,32'h0,1,32'hFFFFFF80,1,0);
      table_v[3]  = mkv(1,0,2'd0,1,32'h1003,32'h0,5'd7,32'h0,1,0,0,32'h80AABBCC,0,
                        0,4'b1000,32'h1000,32'h0,1,32'h00000080,1,0);
      table_v[4]  = mkv(1,1,2'd1,0,32'h2002,32'hDEADBEEF,5'd9,32'h0,1,3,1,32'h0,0,
                        0,4'b1100,32'h2000,32'hBEEFBEEF,0,32'h0,0,0);
      table_v[5]  = mkv(1,0,2'd2,0,32'h3001,32'h0,5'd4,32'h0,1,0,0,32'h0,0,
                        1,4'b0000,32'h0,32'h0,0,32'h0,0,0);
      table_v[6]  = mkv(1,0,2'd2,0,32'h4000,32'h0,5'd6,32'h0,1,0,0,32'h12345678,1,
                        0,4'b1111,32'h4000,32'h0,0,32'h0,0,1);
      table_v[7]  = mkv(1,0,2'd1,0,32'h5002,32'h0,5'd8,32'h0,1,1,0,32'h80017FFF,0,
                        0,4'b1100,32'h5000,32'h0,1,32'hFFFF8001,1,0);
      table_v[8]  = mkv(1,0,2'd1,1,32'h5000,32'h0,5'd10,32'h0,1,0,2,32'h1234F00D,0,
                        0,4'b0011,32'h5000,32'h0,1,32'h0000F00D,1,0);
      table_v[9]  = mkv(1,1,2'd0,0,32'h6001,32'h000000A5,5'd11,32'h0,0,2,0,32'h0,0,
                        0,4'b0010,32'h6000,32'hA5A5A5A5,0,32'h0,0,0);
      table_v[10] = mkv(1,1,2'd2,0,32'h7004,32'hCAFEBABE,5'd12,32'h0,0,0,0,32'h0,0,
                        0,4'b1111,32'h7004,32'hCAFEBABE,0,32'h0,0,0);
      table_v[11] = mkv(1,0,2'd3,0,32'h8000,32'h0,5'd3,32'h0,1,0,0,32'h0,0,
                        1,4'b0000,32'h0,32'h0,0,32'h0,0,0);
      table_v[12] = mkv(1,0,2'd1,0,32'h9001,32'h0,5'd3,32'h0,1,0,0,32'h0,0,
                        1,4'b0000,32'h0,32'h0,0,32'h0,0,0);
      table_v[13] = mkv(1,0,2'd2,0,32'hA000,32'h0,5'd0,32'h0,1,0,0,32'h00000011,0,
                        0,4'b1111,32'hA000,32'h0,0,32'h00000011,1,0);
      table_v[14] = mkv(1,0,2'd0,0,32'hB002,32'h0,5'd13,32'h0,1,0,0,32'h007F0000,0,
                        0,4'b0100,32'hB000,32'h0,1,32'h0000007F,1,0);

      rst_n = 0;
      drive_idle();
      data_gnt = 0; data_rvalid = 0; data_rdata = 0; data_err = 0;
      #12;
      check("rst_stall", stall, 0);
      check("rst_req", data_req, 0);
      check("rst_be", data_be, 0);
      check("rst_addr", data_addr, 0);
      check("rst_wen", reg_wen_out, 0);
      check("rst_wdata", reg_wdata_out, 0);
      check("rst_mis", misaligned, 0);
      check("rst_buserr", bus_err, 0);
      @(posedge clk); #1;
      rst_n = 1;

      foreach (table_v[i]) apply(table_v[i]);

      for (int n = 0; n < 250; n++) begin
         rv.mem = 1'($urandom);
         rv.we = 1'($urandom);
         rv.size = 2'($urandom);
         rv.uns = 1'($urandom);
         rv.addr = $urandom;
         rv.wdata = $urandom;
         rv.rd = 5'($urandom);
         rv.alu = $urandom;
         rv.wen = 1'($urandom);
         rv.gdly = $urandom_range(0, 3);
         rv.rdly = $urandom_range(0, 2);
         rv.rdata = $urandom;
         rv.err = ($urandom_range(0, 7) == 0);
         apply(model(rv));
      end

      // Reset while a request is pending, then a stale response.
      apply(model(mkv(0,0,2'd0,0,32'h0,32'h0,5'd3,32'hAAAA,1,0,0,32'h0,0,
                      0,4'b0,32'h0,32'h0,0,32'h0,0,0)));
      ex_valid = 1; mem_req = 1; mem_we = 0; mem_size = 2'd2; mem_addr = 32'h100;
      reg_waddr_in = 5'd14; reg_wen_in = 1;
      @(posedge clk); #1;
      drive_idle();
      data_gnt = 0;
      check("rstmid_req_before", data_req, 1);
      #2;
      rst_n = 0;
      #1;
      check("rstmid_req", data_req, 0);
      check("rstmid_stall", stall, 0);
      check("rstmid_addr", data_addr, 0);
      check("rstmid_be", data_be, 0);
      check("rstmid_waddr", reg_waddr_out, 0);
      check("rstmid_wdata", reg_wdata_out, 0);
      @(posedge clk); #1;
      rst_n = 1;
      data_rvalid = 1; data_rdata = 32'h77; data_err = 0;
      @(posedge clk); #1;
      data_rvalid = 0;
      check("late_rvalid_wen", reg_wen_out, 0);
      check("late_rvalid_wdata", reg_wdata_out, 0);
      check("late_rvalid_stall", stall, 0);
      check("late_rvalid_req", data_req, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
